// File: rtl/fifo_rd_drain_ctrl.sv
// fifo_rd_drain_ctrl: read-side master draining an async FIFO into a credit-tracked valid/ready buffer.
// Define FIFO_RD_STATS_EN to build the rd_count delivery counter and the sticky underflow flag.
module fifo_rd_drain_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [15:0]           rd_count,
    output logic                  underflow
);
    localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t                state, state_nx;
    logic [RD_LATENCY-1:0] pipe;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         occ, inflight, credit;
    logic                  push, pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push     = pipe[RD_LATENCY-1];
    assign pop      = m_valid && m_ready;
    assign m_valid  = occ != '0;
    assign m_data   = mem[rd_ptr];
    assign busy     = state != IDLE;
    // Words already requested count against buffer space; a pop this cycle frees one slot.
    assign credit     = occ + inflight - CW'(pop);
    assign fifo_rd_en = state == ACTIVE && !fifo_empty && credit < CW'(BUF_DEPTH);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(pipe[i]);
    end

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE   ? (enable ? ACTIVE : IDLE) :
                   state == ACTIVE ? (enable ? ACTIVE : DRAIN) :
                   enable ? ACTIVE : (inflight == '0 && occ == '0) ? IDLE : DRAIN;
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pipe  <= '0;
        end else begin
            state <= state_nx;
            pipe  <= RD_LATENCY'({pipe, fifo_rd_en});
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= fifo_rdata;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (pop) rd_ptr <= wrap_inc(rd_ptr);
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count  <= '0;
            underflow <= 1'b0;
        end else begin
            if (pop) rd_count <= rd_count + 16'd1;
            if (fifo_rd_en && fifo_empty) underflow <= 1'b1;
        end
    end
`else
    assign rd_count  = '0;
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_drain_ctrl.sv
// tb_fifo_rd_drain_ctrl: directed checks of fifo_rd_drain_ctrl against a behavioural FIFO model.
// Instance a uses default parameters; instance b uses RD_LATENCY=2, BUF_DEPTH=3.
module tb_fifo_rd_drain_ctrl;
`ifdef FIFO_RD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en_a = 1'b0, ready_a = 1'b0, en_b = 1'b0, ready_b = 1'b0;
    logic        empty_a, rd_en_a, valid_a, busy_a, uf_a;
    logic        empty_b, rd_en_b, valid_b, busy_b, uf_b;
    logic [7:0]  rdata_a = '0, rdata_b = '0, rd_d_b = '0, data_a, data_b;
    logic [15:0] cnt_a, cnt_b;
    logic [7:0]  mem_a [64];
    logic [7:0]  mem_b [64];
    int          wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;

    assign empty_a = (rp_a == wp_a);
    assign empty_b = (rp_b == wp_b);

    fifo_rd_drain_ctrl u_a (
        .rd_clk(clk), .rst_n(rst_n), .enable(en_a), .fifo_empty(empty_a), .fifo_rdata(rdata_a),
        .fifo_rd_en(rd_en_a), .m_valid(valid_a), .m_data(data_a), .m_ready(ready_a),
        .busy(busy_a), .rd_count(cnt_a), .underflow(uf_a)
    );

    fifo_rd_drain_ctrl #(.DATA_WIDTH(8), .RD_LATENCY(2), .BUF_DEPTH(3)) u_b (
        .rd_clk(clk), .rst_n(rst_n), .enable(en_b), .fifo_empty(empty_b), .fifo_rdata(rdata_b),
        .fifo_rd_en(rd_en_b), .m_valid(valid_b), .m_data(data_b), .m_ready(ready_b),
        .busy(busy_b), .rd_count(cnt_b), .underflow(uf_b)
    );

    always @(posedge clk) begin
        if (rd_en_a) begin
            rdata_a <= mem_a[rp_a[5:0]];
            rp_a    <= rp_a + 1;
        end
        if (rd_en_b) begin
            rd_d_b <= mem_b[rp_b[5:0]];
            rp_b   <= rp_b + 1;
        end
        rdata_b <= rd_d_b;
    end

    int         cyc = 0, rds_a = 0, rds_b = 0, ng_a = 0, ng_b = 0, bad_rd = 0, max_out_b = 0;
    logic [7:0] got_a [256];
    int         gcyc_a [256];
    logic [7:0] got_b [256];

    always @(negedge clk) begin
        cyc++;
        if (rd_en_a) rds_a++;
        if (rd_en_b) rds_b++;
        if ((rd_en_a && (empty_a || !busy_a)) || (rd_en_b && (empty_b || !busy_b))) bad_rd++;
        if (valid_a && ready_a) begin
            got_a[ng_a[7:0]]  = data_a;
            gcyc_a[ng_a[7:0]] = cyc;
            ng_a++;
        end
        if (valid_b && ready_b) begin
            got_b[ng_b[7:0]] = data_b;
            ng_b++;
        end
        if (rds_b - ng_b > max_out_b) max_out_b = rds_b - ng_b;
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] v);
        mem_a[wp_a[5:0]] = v;
        wp_a++;
    endtask

    task automatic flush_a();
        wp_a = rp_a;
    endtask

    task automatic wait_ng_a(input int n, input int budget, input string name);
        int k = 0;
        while (ng_a < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, 32'(ng_a >= n), 32'd1);
    endtask

    task automatic wait_idle_a(input int budget, input string name);
        int k = 0;
        while (busy_a && k < budget) begin
            tick();
            k++;
        end
        chk(name, 32'(busy_a), 32'd0);
    endtask

    typedef struct packed {
        logic       en, rdy, psh;
        logic [7:0] wd;
        logic       exp_rd, exp_v, exp_busy, chkd;
        logic [7:0] exp_d;
    } vec_t;

    vec_t tbl [11];
    int   br, bg;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        tick(2);
        rst_n = 1'b1;
        tick();
        chk("reset_cnt", 32'(cnt_a), 32'd0);
        chk("reset_uf", 32'(uf_a), 32'd0);

        for (int i = 0; i < 11; i++) begin
            en_a    = tbl[i].en;
            ready_a = tbl[i].rdy;
            if (tbl[i].psh) push_a(tbl[i].wd);
            @(negedge clk);
            chk($sformatf("vec%0d_rd_en", i), 32'(rd_en_a), 32'(tbl[i].exp_rd));
            chk($sformatf("vec%0d_valid", i), 32'(valid_a), 32'(tbl[i].exp_v));
            chk($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(tbl[i].exp_busy));
            if (tbl[i].chkd) chk($sformatf("vec%0d_data", i), 32'(data_a), 32'(tbl[i].exp_d));
            tick();
        end
        chk("vec_cnt", 32'(cnt_a), STATS ? 32'd3 : 32'd0);
        flush_a();

        // reset asserted mid-stream with two words buffered
        ready_a = 1'b0;
        en_a    = 1'b1;
        push_a(8'h61); push_a(8'h62); push_a(8'h63);
        tick(6);
        chk("rst_pre_valid", 32'(valid_a), 32'd1);
        chk("rst_pre_data", 32'(data_a), 32'h61);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_data", 32'(data_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_rd_en", 32'(rd_en_a), 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        chk("rst_uf", 32'(uf_a), 32'd0);
        en_a = 1'b0;
        tick(2);
        rst_n = 1'b1;
        flush_a();
        tick(3);
        chk("rst_after_valid", 32'(valid_a), 32'd0);

        // streaming
        bg = ng_a;
        for (int i = 1; i <= 10; i++) push_a(8'(i));
        ready_a = 1'b1;
        en_a    = 1'b1;
        wait_ng_a(bg + 10, 60, "stream_done");
        for (int i = 0; i < 10; i++)
            chk($sformatf("stream_data%0d", i), 32'(got_a[8'(bg + i)]), 32'(i + 1));
        for (int i = 1; i < 10; i++)
            chk($sformatf("stream_gap%0d", i), 32'(gcyc_a[8'(bg + i)] - gcyc_a[8'(bg + i - 1)]), 32'd1);
        chk("stream_cnt", 32'(cnt_a), STATS ? 32'd10 : 32'd0);
        en_a = 1'b0;
        wait_idle_a(20, "stream_idle");

        // backpressure
        flush_a();
        ready_a = 1'b0;
        br = rds_a;
        bg = ng_a;
        for (int i = 0; i < 5; i++) push_a(8'(8'hA1 + i));
        en_a = 1'b1;
        tick(10);
        chk("bp_reads", 32'(rds_a - br), 32'd2);
        chk("bp_valid", 32'(valid_a), 32'd1);
        chk("bp_data", 32'(data_a), 32'hA1);
        tick(3);
        chk("bp_hold", 32'(data_a), 32'hA1);
        chk("bp_reads_hold", 32'(rds_a - br), 32'd2);
        ready_a = 1'b1;
        wait_ng_a(bg + 5, 40, "bp_done");
        for (int i = 0; i < 5; i++)
            chk($sformatf("bp_data%0d", i), 32'(got_a[8'(bg + i)]), 32'(8'hA1 + i));
        en_a = 1'b0;
        wait_idle_a(20, "bp_idle");

        // empty boundary: a single word
        flush_a();
        br = rds_a;
        bg = ng_a;
        en_a = 1'b1;
        tick(2);
        push_a(8'h5A);
        tick(8);
        chk("empty_reads", 32'(rds_a - br), 32'd1);
        chk("empty_rd_en", 32'(rd_en_a), 32'd0);
        chk("empty_uf", 32'(uf_a), 32'd0);
        chk("empty_words", 32'(ng_a - bg), 32'd1);
        chk("empty_data", 32'(got_a[8'(bg)]), 32'h5A);
        en_a = 1'b0;
        wait_idle_a(20, "empty_idle");

        // graceful stop with one word buffered and one in flight
        flush_a();
        ready_a = 1'b0;
        br = rds_a;
        bg = ng_a;
        en_a = 1'b1;
        tick();
        push_a(8'h71); push_a(8'h72); push_a(8'h73);
        tick(2);
        chk("stop_pre_valid", 32'(valid_a), 32'd1);
        chk("stop_pre_reads", 32'(rds_a - br), 32'd2);
        en_a = 1'b0;
        tick(5);
        chk("stop_no_rd", 32'(rds_a - br), 32'd2);
        chk("stop_busy", 32'(busy_a), 32'd1);
        ready_a = 1'b1;
        wait_idle_a(20, "stop_idle");
        chk("stop_words", 32'(ng_a - bg), 32'd2);
        chk("stop_data0", 32'(got_a[8'(bg)]), 32'h71);
        chk("stop_data1", 32'(got_a[8'(bg + 1)]), 32'h72);
        chk("stop_reads_final", 32'(rds_a - br), 32'd2);
        flush_a();

        // latency 2, depth 3, toggling ready
        for (int i = 0; i < 20; i++) begin
            mem_b[wp_b[5:0]] = 8'(8'h30 + i);
            wp_b++;
        end
        en_b = 1'b1;
        for (int k = 0; k < 300 && ng_b < 20; k++) begin
            ready_b = ~ready_b;
            tick();
        end
        ready_b = 1'b1;
        tick(10);
        en_b = 1'b0;
        tick(3);
        chk("b_count", 32'(ng_b), 32'd20);
        for (int i = 0; i < 20; i++)
            chk($sformatf("b_data%0d", i), 32'(got_b[8'(i)]), 32'(8'h30 + i));
        chk("b_reads", 32'(rds_b), 32'd20);
        chk("b_max_occ", 32'(max_out_b <= 3), 32'd1);
        chk("b_busy", 32'(busy_b), 32'd0);
        chk("b_cnt", 32'(cnt_b), STATS ? 32'd20 : 32'd0);

        chk("no_bad_reads", 32'(bad_rd), 32'd0);
        chk("uf_a_final", 32'(uf_a), 32'd0);
        chk("uf_b_final", 32'(uf_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
